decode_stage_ctrl: RTL



---
 rtl/decode_pkg.sv | 68 ++++++
 rtl/decode_skid_buffer.sv | 71 +++++++
 rtl/decode_stage_ctrl.sv | 62 ++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: immediate-type codes, RV64 opcodes,
// the buffered entry record and the opcode classifier.
// DECODE_ILLEGAL_TRAP_EN adds a stored illegal-opcode flag to each entry.
package decode_pkg;

    // Immediate-type codes consumed by the core's immediate decoder
    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    // RV64 base opcodes
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_MISCMEM = 7'b0001111;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_IMM32   = 7'b0011011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_OP32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    // One buffered instruction with its precomputed class
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [2:0]  immType;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } decodeEntry_t;

    // Opcode -> immediate type; anything unrecognised maps to IMM_NONE.
    // All legal opcodes end in 2'b11, so a full 7-bit match also rejects
    // compressed/invalid low bits.
    function automatic logic [2:0] classifyImm(input logic [6:0] opcode);
        logic [2:0] t;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32,
            OP_JALR, OP_SYSTEM, OP_MISCMEM: t = IMM_I;
            OP_STORE:                       t = IMM_S;
            OP_BRANCH:                      t = IMM_B;
            OP_LUI, OP_AUIPC:               t = IMM_U;
            OP_JAL:                         t = IMM_J;
            default:                        t = IMM_NONE;
        endcase
        return t;
    endfunction

    // True when the opcode is not part of the recognised set
    function automatic logic isIllegal(input logic [6:0] opcode);
        logic ill;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM, OP_MISCMEM,
            OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL,
            OP_OP, OP_OP32: ill = 1'b0;
            default:        ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry valid/ready skid buffer with flush carrying decodeEntry_t.
// Handshake: a transfer happens on an edge where valid && ready are both high;
// valid never waits on ready, and inReady is a flop (!skidValid) so no input
// reaches any output combinationally.
module decode_skid_buffer
    import decode_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         inValid,
    output logic         inReady,
    input  decodeEntry_t inEntry,
    output logic         outValid,
    input  logic         outReady,
    output decodeEntry_t outEntry
);

    logic         mainValid;
    logic         skidValid;
    decodeEntry_t mainEntry;
    decodeEntry_t skidEntry;
    logic         inFire;
    logic         outFire;

    // Transfer strobes for this cycle
    always_comb begin
        inFire  = inValid && !skidValid;
        outFire = mainValid && outReady;
    end

    // Entry storage: main feeds the outputs, skid absorbs one overflow beat
    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid         <= 1'b0;
            skidValid         <= 1'b0;
            mainEntry         <= '0;
            mainEntry.immType <= IMM_NONE;
            skidEntry         <= '0;
        end else if (flush) begin
            // Transfers in the flush cycle are dropped entirely
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else if (outFire || !mainValid) begin
            // Main is free this edge; skid (older) has priority over fetch.
            // inFire cannot coincide with skidValid because inReady is low.
            if (skidValid) begin
                mainEntry <= skidEntry;
                mainValid <= 1'b1;
                skidValid <= 1'b0;
            end else if (inFire) begin
                mainEntry <= inEntry;
                mainValid <= 1'b1;
            end else begin
                mainValid <= 1'b0;
            end
        end else if (inFire) begin
            // Main held by back-pressure: park the new beat in skid
            skidEntry <= inEntry;
            skidValid <= 1'b1;
        end
    end

    // Registered outputs
    always_comb begin
        inReady  = !skidValid;
        outValid = mainValid;
        outEntry = mainEntry;
    end

endmodule

// File: rtl/decode_stage_ctrl.sv
// Decode-stage controller: classifies fetched opcodes at acceptance and
// presents registered instruction/PC/immType to execute through a skid buffer.
// DECODE_ILLEGAL_TRAP_EN enables the stored illegal-opcode flag on dillegal.
module decode_stage_ctrl
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fvalid,
    output logic        fready,
    input  logic [31:0] finst,
    input  logic [63:0] fpc,
    input  logic        flush,
    output logic        dvalid,
    input  logic        dready,
    output logic [24:0] dinstTop,
    output logic [6:0]  dopcode,
    output logic [63:0] dpc,
    output logic [2:0]  immType,
    output logic        dillegal
);

    decodeEntry_t fetchEntry;
    decodeEntry_t presEntry;

    // Build the entry from the fetch bus, classifying the opcode up front
    always_comb begin
        fetchEntry         = '0;
        fetchEntry.inst    = finst;
        fetchEntry.pc      = fpc;
        fetchEntry.immType = classifyImm(finst[6:0]);
`ifdef DECODE_ILLEGAL_TRAP_EN
        fetchEntry.illegal = isIllegal(finst[6:0]);
`endif
    end

    decode_skid_buffer uBuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (fvalid),
        .inReady  (fready),
        .inEntry  (fetchEntry),
        .outValid (dvalid),
        .outReady (dready),
        .outEntry (presEntry)
    );

    // Split the presented entry onto the execute-side ports
    always_comb begin
        dinstTop = presEntry.inst[31:7];
        dopcode  = presEntry.inst[6:0];
        dpc      = presEntry.pc;
        immType  = presEntry.immType;
`ifdef DECODE_ILLEGAL_TRAP_EN
        dillegal = presEntry.illegal;
`else
        dillegal = 1'b0;
`endif
    end

endmodule
